pulse_train_gen: RTL and testbench
==================================

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter: CNT_W, 16, width of the high and low phase-length counters.
REQ-002 Parameter: NUM_W, 8, width of the pulse-count field.
REQ-003 Port: clk  input  1  single clock; all logic on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 Port: start  input  1  request to begin a pulse train; sampled only in IDLE.
REQ-006 Port: abort  input  1  terminates an active train; has priority over start.
REQ-007 Port: high_cycles  input  CNT_W  high-phase length in clocks; latched on start accept.
REQ-008 Port: low_cycles  input  CNT_W  low-phase length in clocks; latched on start accept.
REQ-009 Port: pulse_count  input  NUM_W  number of pulses to emit; latched on start accept.
REQ-010 Port: pulse_out  output  1  generated pulse waveform, registered.
REQ-011 Port: busy  output  1  high from the cycle after start accept until train completion or abort, registered.
REQ-012 Port: done  output  1  one-cycle strobe on normal completion, registered.

Function
REQ-013 The block SHALL be the transmit-side counterpart of the team's edge detectors: it SHALL produce clean, cycle-exact rising and falling edges on pulse_out.
REQ-014 The FSM SHALL have states IDLE, HIGH and LOW.
REQ-015 Start accept: in IDLE, start=1 and abort=0 SHALL latch high_cycles, low_cycles and pulse_count.
REQ-016 Zero lengths: a latched phase length of 0 SHALL be treated as 1.
REQ-017 Start accept with pulse_count≠0: the FSM SHALL enter HIGH at the next edge, with pulse_out=1 and busy=1 in the first cycle after accept.
REQ-018 Start accept with pulse_count=0: the FSM SHALL stay in IDLE, pulse_out SHALL stay 0, busy SHALL stay 0, and done SHALL be 1 in the next cycle.
REQ-019 HIGH state: pulse_out=1 for exactly H cycles (H = latched high length), then LOW.
REQ-020 LOW state: pulse_out=0 for exactly L cycles (L = latched low length), with one period = H+L cycles.
REQ-021 After the LOW phase of pulse k<N (N = latched count): the FSM SHALL return to HIGH with no gap cycle.
REQ-022 After the LOW phase of pulse N: the FSM SHALL enter IDLE, with busy=0 and done=1 in the first IDLE cycle only.
REQ-023 Total busy time: busy SHALL be high for exactly N*(H+L) cycles.
REQ-024 Restart: start asserted in the cycle done=1 SHALL be accepted, giving back-to-back trains with exactly one idle cycle between them.
REQ-025 start while busy=1 SHALL be ignored, and the latched configuration SHALL NOT change.
REQ-026 Input changes on high_cycles, low_cycles and pulse_count while busy SHALL have no effect.
REQ-027 abort=1 in HIGH or LOW SHALL return the FSM to IDLE at the next edge, with pulse_out=0, busy=0 and done=0 in the following cycle.
REQ-028 abort=1 in IDLE SHALL block a simultaneous start; no state change occurs.
REQ-029 Counters SHALL NOT wrap: all-ones high_cycles/low_cycles SHALL give exactly 2^CNT_W−1 cycles, and all-ones pulse_count SHALL give exactly 2^NUM_W−1 pulses.
REQ-030 pulse_out SHALL be glitch-free: driven directly from a flop, with no combinational path from any input to any output.

Reset
REQ-031 Outputs during reset: reset=1 at a clock edge SHALL force IDLE, pulse_out=0, busy=0, done=0, and clear the latched configuration and counters.
REQ-032 Reset mid-train: reset asserted in HIGH or LOW SHALL take effect at that edge with no done strobe, and SHALL override start and abort.
REQ-033 Release from reset: the block SHALL accept start on the first cycle after reset deasserts.

Verification
REQ-034 H=3, L=2, N=4, start one cycle -> pulse_out pattern 11100 repeated 4 times from cycle+1, busy high 20 cycles, then done=1 for 1 cycle.
REQ-035 H=0, L=0, N=3 -> pulse_out toggles 101010 (each phase 1 cycle), busy 6 cycles, then done.
REQ-036 N=0, start -> pulse_out=0, busy=0 throughout, done=1 exactly one cycle after accept.
REQ-037 H=5, L=5, N=2, abort at the 3rd HIGH cycle -> pulse_out=0 and busy=0 next cycle, done never asserted; a start two cycles later is accepted normally.
REQ-038 H=2, L=1, N=1 with start held high continuously -> trains repeat with exactly one idle cycle (done=1) between them; start pulses while busy are ignored.
REQ-039 Reset asserted at the 7th cycle of an H=4, L=4, N=3 train -> all outputs 0 next cycle, no done; a fresh start after release produces a full, correct train.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits pulse_count pulses of high_cycles high / low_cycles low.
// All outputs come straight from flops, so pulse_out edges are clean and cycle-exact.
module pulse_train_gen #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NUM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [NUM_W-1:0] pulse_count,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] high_m1_q;
  logic [CNT_W-1:0] low_m1_q;
  logic [CNT_W-1:0] phase_cnt_q;
  logic [NUM_W-1:0] pulses_left_q;
  logic             pulse_q;
  logic             busy_q;
  logic             done_q;

  // Phase counters hold "cycles remaining minus one"; a zero length collapses to one cycle.
  logic [CNT_W-1:0] high_in_m1;
  logic [CNT_W-1:0] low_in_m1;

  always_comb begin
    high_in_m1 = (high_cycles == '0) ? '0 : high_cycles - CNT_W'(1);
    low_in_m1  = (low_cycles == '0) ? '0 : low_cycles - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      high_m1_q     <= '0;
      low_m1_q      <= '0;
      phase_cnt_q   <= '0;
      pulses_left_q <= '0;
      pulse_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            high_m1_q     <= high_in_m1;
            low_m1_q      <= low_in_m1;
            pulses_left_q <= pulse_count;
            if (pulse_count != '0) begin
              state_q     <= StHigh;
              phase_cnt_q <= high_in_m1;
              pulse_q     <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StHigh: begin
          if (abort) begin
            state_q <= StIdle;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (phase_cnt_q == '0) begin
            state_q     <= StLow;
            phase_cnt_q <= low_m1_q;
            pulse_q     <= 1'b0;
          end else begin
            phase_cnt_q <= phase_cnt_q - CNT_W'(1);
          end
        end
        StLow: begin
          if (abort) begin
            state_q <= StIdle;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (phase_cnt_q == '0) begin
            if (pulses_left_q == NUM_W'(1)) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // Next pulse starts immediately, no gap cycle.
              state_q       <= StHigh;
              phase_cnt_q   <= high_m1_q;
              pulses_left_q <= pulses_left_q - NUM_W'(1);
              pulse_q       <= 1'b1;
            end
          end else begin
            phase_cnt_q <= phase_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: a per-cycle vector table plus procedural train checks.
module tb_pulse_train_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] high_cycles;
  logic [15:0] low_cycles;
  logic [7:0]  pulse_count;
  logic        pulse_out;
  logic        busy;
  logic        done;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pulse_train_gen #(
    .CNT_W(16),
    .NUM_W(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .high_cycles(high_cycles),
    .low_cycles (low_cycles),
    .pulse_count(pulse_count),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic        ab;
    logic [15:0] h;
    logic [15:0] l;
    logic [7:0]  n;
    logic        ep;
    logic        eb;
    logic        ed;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic st, logic ab, int h, int l, int n,
                              logic ep, logic eb, logic ed);
    vec_t v;
    v.rst = rst; v.st = st; v.ab = ab;
    v.h = 16'(h); v.l = 16'(l); v.n = 8'(n);
    v.ep = ep; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic check(string name, int idx, logic ep, logic eb, logic ed);
    nvec++;
    if (pulse_out !== ep || busy !== eb || done !== ed) begin
      nerr++;
      $display("FAIL %s #%0d: got pulse/busy/done=%b%b%b expected %b%b%b",
               name, idx, pulse_out, busy, done, ep, eb, ed);
    end
  endtask

  // Runs one train from IDLE; expected waveform derived from period arithmetic.
  task automatic train(string name, int h, int l, int n, bit hold);
    int hh = (h == 0) ? 1 : h;
    int ll = (l == 0) ? 1 : l;
    int p  = hh + ll;
    int total = n * p;
    high_cycles = 16'(h);
    low_cycles  = 16'(l);
    pulse_count = 8'(n);
    start       = 1'b1;
    abort       = 1'b0;
    for (int c = 0; c < total; c++) begin
      @(posedge clk);
      #1;
      check(name, c, ((c % p) < hh), 1'b1, 1'b0);
      if (c == 0) begin
        if (!hold) start = 1'b0;
        high_cycles = 16'($urandom);
        low_cycles  = 16'($urandom);
        pulse_count = 8'($urandom);
      end
      if (c == total - 1) begin
        high_cycles = 16'(h);
        low_cycles  = 16'(l);
        pulse_count = 8'(n);
      end
    end
    @(posedge clk);
    #1;
    check(name, total, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset, then H=0 L=0 N=3 toggling
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 3, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 3, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 3, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0));
    // N=0: done only
    vq.push_back(mk(0, 1, 0, 5, 5, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 5, 5, 0, 0, 0, 0));
    // abort in IDLE blocks start
    vq.push_back(mk(0, 1, 1, 2, 2, 3, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 2, 2, 3, 0, 0, 0));
    // H=5 L=5 N=2, abort in 3rd HIGH cycle, restart two cycles later
    vq.push_back(mk(0, 1, 0, 5, 5, 2, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 5, 5, 2, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 5, 5, 2, 1, 1, 0));
    vq.push_back(mk(0, 0, 1, 5, 5, 2, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 5, 5, 2, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 1, 1, 1, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 1, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0));
    // H=2 L=1 N=2 with start/config changes while busy ignored
    vq.push_back(mk(0, 1, 0, 2, 1, 2, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 7, 7, 9, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 7, 7, 9, 0, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    // H=4 L=4 N=3, reset at 7th cycle overriding start/abort, start right after release
    vq.push_back(mk(0, 1, 0, 4, 4, 3, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 4, 4, 3, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 4, 4, 3, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 4, 4, 3, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 4, 4, 3, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 4, 4, 3, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 4, 4, 3, 0, 1, 0));
    vq.push_back(mk(1, 1, 1, 4, 4, 3, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 1, 2, 1, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 2, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 2, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 2, 1, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 1, 2, 1, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      reset       = vq[i].rst;
      start       = vq[i].st;
      abort       = vq[i].ab;
      high_cycles = vq[i].h;
      low_cycles  = vq[i].l;
      pulse_count = vq[i].n;
      @(posedge clk);
      #1;
      check("table", i, vq[i].ep, vq[i].eb, vq[i].ed);
    end

    reset = 1'b0;
    train("h3l2n4", 3, 2, 4, 1'b0);
    train("h4l4n3_after_reset", 4, 4, 3, 1'b0);
    // Start held: second train accepted in the done cycle, one idle cycle between
    train("held_a", 2, 1, 1, 1'b1);
    train("held_b", 2, 1, 1, 1'b1);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("held_stop", 0, 1'b0, 1'b0, 1'b0);
    train("max_count", 0, 0, 255, 1'b0);
    train("max_high", 65535, 1, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
